block_memory_responder: RTL and testbench
=========================================

// Module: block_memory_responder
// PURPOSE
//  Main-memory end of the direct-mapped cache's RAM interface. Serves 128-bit block refills
//  (read) and dirty-victim writebacks (write) with a programmable access latency.
//  Victim writeback always commits before refill when both are requested together.
//  Backing store is a 2**BLOCK_AW x 128-bit array. Sits between the cache and the top-level data bus.
// PARAMETERS
//  BLOCK_AW  4   block-address width; array depth is 2**BLOCK_AW blocks
//  LATENCY   4   wait cycles per access, legal range 1..15; a 4-bit down-counter
// PORTS
//  clk              in   1    clock; all logic on posedge
//  reset            in   1    synchronous, active-low reset
//  rdReq            in   1    refill request; sampled only in IDLE
//  rdAddress        in   BLOCK_AW  block to refill (addr[5:2] with BLOCK_AW=4)
//  wrReq            in   1    writeback request (the cache's writetomem); sampled only in IDLE
//  wrAddress        in   BLOCK_AW  victim block address (old tag & line)
//  dataInFromCache  in   128  victim block, word0 = [31:0]
//  dataOutToCache   out  128  refill block; held stable from rdValid until the next read completes
//  busy             out  1    high whenever the state is not IDLE
//  rdValid          out  1    one-cycle pulse: dataOutToCache is valid
//  wrDone           out  1    one-cycle pulse: writeback committed to the array
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, busy=0, rdValid=0, wrDone=0, dataOutToCache=0,
//   counter=0, pending flags cleared. Array contents are NOT reset.
//  Reset mid-operation aborts the access: no write commit and no rdValid.
//  States: IDLE, WR_WAIT, WR_COMMIT, RD_WAIT, RD_DONE.
//  IDLE: capture rdAddress, wrAddress and dataInFromCache into internal registers when any request is high.
//   wrReq=1 (with or without rdReq): go to WR_WAIT, cnt=LATENCY-1, rdPend=rdReq.
//   rdReq=1 only: go to RD_WAIT, cnt=LATENCY-1.
//  WR_WAIT: decrement cnt; when cnt==0, go to WR_COMMIT.
//  WR_COMMIT: write the array at the latched wrAddress; wrDone=1 this cycle.
//   If rdPend, go to RD_WAIT with cnt=LATENCY-1; otherwise go to IDLE.
//  RD_WAIT: decrement cnt; when cnt==0, go to RD_DONE.
//  RD_DONE: dataOutToCache <= array at the latched rdAddress; rdValid=1 next cycle; go to IDLE.
//  Latency, write only: wrDone is high LATENCY+1 cycles after the request-sampling edge.
//  Latency, read only: rdValid is high LATENCY+2 cycles after that edge.
//  Combined request: rdValid is high 2*LATENCY+3 cycles after that edge.
//  rdReq and wrReq are ignored while busy=1; inputs may change freely once sampled.
//  Same-address combined request (rdAddress==wrAddress): the read returns the newly written block
//   (write before read).
//  A back-to-back request presented in the cycle rdValid/wrDone pulses is accepted, because state is IDLE.
//  An address wraps modulo 2**BLOCK_AW; no out-of-range case exists.
//  The cache samples on negedge, so outputs are registered on posedge and stable at negedge.
// TESTING
//  1 Reset: hold reset=0 for 3 cycles with rdReq=1 -> busy=0, rdValid=0, wrDone=0, dataOutToCache=0.
//  2 Write then read: wrReq at addr 4'h5 with data 128'hDEAD..0001 -> wrDone pulse at +5 cycles;
//    then rdReq at 4'h5 -> rdValid at +6 cycles, data 128'hDEAD..0001.
//  3 Combined request: wrAddress=4'h2 (data A), rdAddress=4'h6 (preloaded with B) -> wrDone at +5,
//    rdValid at +11, dataOutToCache=B, and a later read of 4'h2 returns A.
//  4 Same-address combined request at 4'h3 with new data C -> rdValid returns C, not the old contents.
//  5 Ignore while busy: pulse rdReq at 4'h1 during an active RD_WAIT -> exactly one rdValid;
//    data is from the first address.
//  6 Mid-operation reset: assert reset=0 in WR_WAIT -> no wrDone; a later read of that address
//    returns the old contents.
//    With LATENCY=1: a read-only request gives rdValid at +3.

Source files
------------

// File: rtl/block_memory_responder.sv
// Main-memory side of the cache RAM interface: serves 128-bit block refills
// and dirty-victim writebacks from a 2**BLOCK_AW x 128 backing array, each
// access taking LATENCY wait cycles. When both arrive together the writeback
// commits first, so a same-address refill returns the freshly written block.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting; requests sampled, addresses and victim data latched
// WR_WAIT   | writeback latency countdown
// WR_COMMIT | victim block written to the array, wrDone issued
// RD_WAIT   | refill latency countdown
// RD_DONE   | refill block read from the array into the output register
module block_memory_responder #(
  parameter int BLOCK_AW = 4,
  parameter int LATENCY  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rdReq,
  input  logic [BLOCK_AW-1:0] rdAddress,
  input  logic                wrReq,
  input  logic [BLOCK_AW-1:0] wrAddress,
  input  logic [127:0]        dataInFromCache,
  output logic [127:0]        dataOutToCache,
  output logic                busy,
  output logic                rdValid,
  output logic                wrDone
);

  localparam int          DEPTH    = 2 ** BLOCK_AW;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_COMMIT,
    RD_WAIT,
    RD_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic [BLOCK_AW-1:0] rd_addr_q, rd_addr_d;
  logic [BLOCK_AW-1:0] wr_addr_q, wr_addr_d;
  logic [127:0]        wr_data_q, wr_data_d;
  logic [127:0]        data_out_q, data_out_d;
  logic                rd_fire_q, rd_fire_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_done_q, wr_done_d;
  logic                mem_we;

  logic [127:0]        mem [DEPTH];

  // Next-state, countdown and output-register logic for the access sequencer.
  // The refill block is captured in RD_DONE and rdValid follows one cycle
  // later, so the data is already stable when the pulse is seen.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_pend_d  = rd_pend_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    data_out_d = data_out_q;
    rd_fire_d  = 1'b0;
    rd_valid_d = rd_fire_q;
    wr_done_d  = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rdReq || wrReq) begin
          rd_addr_d = rdAddress;
          wr_addr_d = wrAddress;
          wr_data_d = dataInFromCache;
        end
        if (wrReq) begin
          state_d   = WR_WAIT;
          cnt_d     = CNT_INIT;
          rd_pend_d = rdReq;
        end else if (rdReq) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WR_WAIT: begin
        if (cnt_q == 4'd0) state_d = WR_COMMIT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      WR_COMMIT: begin
        mem_we    = 1'b1;
        wr_done_d = 1'b1;
        if (rd_pend_q) begin
          state_d   = RD_WAIT;
          cnt_d     = CNT_INIT;
          rd_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) state_d = RD_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RD_DONE: begin
        data_out_d = mem[rd_addr_q];
        rd_fire_d  = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      data_out_q <= '0;
      rd_fire_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      data_out_q <= data_out_d;
      rd_fire_q  <= rd_fire_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
    end
  end

  // Backing store is not reset; a reset coinciding with the commit cancels it.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[wr_addr_q] <= wr_data_q;
  end

  assign dataOutToCache = data_out_q;
  assign busy           = (state_q != IDLE);
  assign rdValid        = rd_valid_q;
  assign wrDone         = wr_done_q;

endmodule

// File: tb/tb_block_memory_responder.sv
// Directed bench for block_memory_responder: latency, ordering, ignore-while-
// busy, reset abort and back-to-back acceptance, plus a LATENCY=1 instance.
module tb_block_memory_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         rdReq, wrReq;
  logic [3:0]   rdAddress, wrAddress;
  logic [127:0] dataIn, dataOut;
  logic         busy, rdValid, wrDone;

  logic         r1_rdReq, r1_wrReq;
  logic [3:0]   r1_rdAddress, r1_wrAddress;
  logic [127:0] r1_dataIn, r1_dataOut;
  logic         r1_busy, r1_rdValid, r1_wrDone;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] D1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_0001;
  localparam logic [127:0] DA = 128'hAAAA_0000_1111_2222_3333_4444_5555_000A;
  localparam logic [127:0] DB = 128'hBBBB_0000_6666_7777_8888_9999_CCCC_000B;
  localparam logic [127:0] C0 = 128'h0C0C_0C0C_0C0C_0C0C_0C0C_0C0C_0C0C_0C0C;
  localparam logic [127:0] DC = 128'hCCCC_1234_5678_9ABC_DEF0_1357_2468_000C;
  localparam logic [127:0] DE = 128'hEEEE_EEEE_0000_0000_FFFF_FFFF_1111_000E;
  localparam logic [127:0] DF = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_000F;
  localparam logic [127:0] DG = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

  always #5 clk = ~clk;

  block_memory_responder #(.BLOCK_AW(4), .LATENCY(4)) u_dut (
    .clk(clk), .reset(reset),
    .rdReq(rdReq), .rdAddress(rdAddress),
    .wrReq(wrReq), .wrAddress(wrAddress),
    .dataInFromCache(dataIn), .dataOutToCache(dataOut),
    .busy(busy), .rdValid(rdValid), .wrDone(wrDone)
  );

  block_memory_responder #(.BLOCK_AW(4), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .rdReq(r1_rdReq), .rdAddress(r1_rdAddress),
    .wrReq(r1_wrReq), .wrAddress(r1_wrAddress),
    .dataInFromCache(r1_dataIn), .dataOutToCache(r1_dataOut),
    .busy(r1_busy), .rdValid(r1_rdValid), .wrDone(r1_wrDone)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request for a single sampling edge, then watch 30 cycles.
  // Cycle c is observed 1 time unit after the c-th edge following sampling.
  // inj>0 raises rdReq at address 1 so it is sampled at edge inj.
  task automatic run_txn(input logic rd, input logic [3:0] ra,
                         input logic wr, input logic [3:0] wa,
                         input logic [127:0] d, input int inj,
                         output int t_wr, output int t_rd,
                         output int n_wr, output int n_rd);
    rdReq = rd; rdAddress = ra; wrReq = wr; wrAddress = wa; dataIn = d;
    @(posedge clk); #1;
    rdReq = 1'b0; wrReq = 1'b0; rdAddress = 4'hF; wrAddress = 4'hE; dataIn = '1;
    t_wr = -1; t_rd = -1; n_wr = 0; n_rd = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == inj) begin
        rdReq = 1'b1; rdAddress = 4'h1;
      end else begin
        rdReq = 1'b0;
      end
      @(posedge clk); #1;
      if (wrDone === 1'b1) begin
        n_wr++;
        if (t_wr < 0) t_wr = c;
      end
      if (rdValid === 1'b1) begin
        n_rd++;
        if (t_rd < 0) t_rd = c;
      end
    end
    rdReq = 1'b0;
  endtask

  int tw, tr, nw, nr, c1;

  initial begin
    reset = 1'b0;
    rdReq = 1'b1; wrReq = 1'b0; rdAddress = 4'h5; wrAddress = 4'h0; dataIn = '0;
    r1_rdReq = 1'b0; r1_wrReq = 1'b0; r1_rdAddress = 4'h0; r1_wrAddress = 4'h0;
    r1_dataIn = '0;

    // reset held with a request present
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_rdvalid", {127'd0, rdValid}, 128'd0);
    check("rst_wrdone", {127'd0, wrDone}, 128'd0);
    check("rst_data", dataOut, 128'd0);
    rdReq = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", {127'd0, busy}, 128'd0);

    // write then read
    run_txn(1'b0, 4'h0, 1'b1, 4'h5, D1, 0, tw, tr, nw, nr);
    check("wr5_lat", 128'(tw), 128'd5);
    check("wr5_npulse", 128'(nw), 128'd1);
    check("wr5_nord", 128'(nr), 128'd0);
    run_txn(1'b1, 4'h5, 1'b0, 4'h0, '0, 0, tw, tr, nw, nr);
    check("rd5_lat", 128'(tr), 128'd6);
    check("rd5_npulse", 128'(nr), 128'd1);
    check("rd5_data", dataOut, D1);

    // combined request, different addresses
    run_txn(1'b0, 4'h0, 1'b1, 4'h6, DB, 0, tw, tr, nw, nr);
    run_txn(1'b1, 4'h6, 1'b1, 4'h2, DA, 0, tw, tr, nw, nr);
    check("comb_wr_lat", 128'(tw), 128'd5);
    check("comb_rd_lat", 128'(tr), 128'd11);
    check("comb_data", dataOut, DB);
    run_txn(1'b1, 4'h2, 1'b0, 4'h0, '0, 0, tw, tr, nw, nr);
    check("rd2_data", dataOut, DA);

    // same-address combined request: write lands before the read
    run_txn(1'b0, 4'h0, 1'b1, 4'h3, C0, 0, tw, tr, nw, nr);
    run_txn(1'b1, 4'h3, 1'b1, 4'h3, DC, 0, tw, tr, nw, nr);
    check("same_rd_lat", 128'(tr), 128'd11);
    check("same_data", dataOut, DC);

    // request while busy is ignored
    run_txn(1'b0, 4'h0, 1'b1, 4'h1, DE, 0, tw, tr, nw, nr);
    run_txn(1'b1, 4'h5, 1'b0, 4'h0, '0, 3, tw, tr, nw, nr);
    check("busy_npulse", 128'(nr), 128'd1);
    check("busy_lat", 128'(tr), 128'd6);
    check("busy_data", dataOut, D1);

    // reset during WR_WAIT cancels the write
    wrReq = 1'b1; wrAddress = 4'h5; dataIn = DF;
    @(posedge clk); #1;
    wrReq = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", {127'd0, busy}, 128'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", {127'd0, busy}, 128'd0);
    reset = 1'b1;
    nw = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (wrDone === 1'b1) nw++;
    end
    check("mid_no_wrdone", 128'(nw), 128'd0);
    run_txn(1'b1, 4'h5, 1'b0, 4'h0, '0, 0, tw, tr, nw, nr);
    check("mid_old_data", dataOut, D1);

    // back-to-back: read issued in the wrDone cycle is accepted
    wrReq = 1'b1; wrAddress = 4'h7; dataIn = DG;
    @(posedge clk); #1;
    wrReq = 1'b0;
    c1 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (wrDone === 1'b1) begin
        c1 = c;
        break;
      end
    end
    check("b2b_wr_lat", 128'(c1), 128'd5);
    rdReq = 1'b1; rdAddress = 4'h7;
    @(posedge clk); #1;
    rdReq = 1'b0;
    c1 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (rdValid === 1'b1) begin
        c1 = c;
        break;
      end
    end
    check("b2b_rd_lat", 128'(c1), 128'd6);
    check("b2b_data", dataOut, DG);

    // LATENCY=1 instance
    r1_wrReq = 1'b1; r1_wrAddress = 4'h9; r1_dataIn = DE;
    @(posedge clk); #1;
    r1_wrReq = 1'b0;
    c1 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (r1_wrDone === 1'b1) begin
        c1 = c;
        break;
      end
    end
    check("l1_wr_lat", 128'(c1), 128'd2);
    repeat (2) @(posedge clk);
    #1;
    r1_rdReq = 1'b1; r1_rdAddress = 4'h9;
    @(posedge clk); #1;
    r1_rdReq = 1'b0;
    c1 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (r1_rdValid === 1'b1) begin
        c1 = c;
        break;
      end
    end
    check("l1_rd_lat", 128'(c1), 128'd3);
    check("l1_rd_data", r1_dataOut, DE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
